bigmul_operand_loader: RTL and testbench



---
 rtl/bigmul_pkg.sv | 32 +++
 rtl/bigmul_operand_loader_if.sv | 12 +
 rtl/bigmul_word_packer.sv | 47 ++++
 rtl/bigmul_operand_loader.sv | 125 ++++++++++++
 tb/tb_bigmul_operand_loader.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bigmul_pkg.sv
// Shared definitions for the big-integer multiplier slice: operand geometry,
// loader state encoding and beat-counter field layout.
package bigmul_pkg;

  localparam int unsigned NWORDS = 64;            // words per operand
  localparam int unsigned WORD_W = 64;            // operand word width
  localparam int unsigned NDIAGS = 2*NWORDS - 1;  // partial-product diagonals
  localparam int unsigned IN_W   = 32;            // loader input beat width
  localparam int unsigned BPW    = WORD_W / IN_W; // beats per word
  localparam int unsigned NBEATS = 2*NWORDS*BPW;  // beats per A+B frame
  localparam int unsigned ADDR_W = $clog2(NWORDS);
  localparam int unsigned BCNT_W = $clog2(NBEATS);

  // Beat-counter fields: [0] half select, [6:1] word address, [7] operand.
  localparam int unsigned BC_HALF_BIT  = 0;
  localparam int unsigned BC_ADDR_LSB  = 1;
  localparam int unsigned BC_OPSEL_BIT = BCNT_W - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_KICK,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } loader_state_e;

  typedef enum logic {
    OP_A = 1'b0,
    OP_B = 1'b1
  } operand_e;

endpackage

// File: rtl/bigmul_operand_loader_if.sv
// Framed valid/ready beat stream feeding the operand loader.
interface bigmul_operand_loader_if #(
  parameter int unsigned IN_W = bigmul_pkg::IN_W
) ();
  logic            valid;
  logic            ready;
  logic [IN_W-1:0] data;
  logic            last;

  modport master (output valid, output data, output last, input  ready);
  modport slave  (input  valid, input  data, input  last, output ready);
endinterface

// File: rtl/bigmul_word_packer.sv
// Packs beat pairs into 64-bit words and issues a registered one-cycle write
// strobe to the A or B operand cache together with address and data.
module bigmul_word_packer #(
  parameter int unsigned IN_W   = 32,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              beat_en,
  input  logic              half,
  input  logic [ADDR_W-1:0] addr,
  input  logic              opsel,
  input  logic [IN_W-1:0]   data,
  output logic              wr_a_en,
  output logic              wr_b_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2*IN_W-1:0] wr_data
);
  import bigmul_pkg::*;

  logic [IN_W-1:0] lo_q;

  // Latch the low half on even beats; emit the packed word on odd beats.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lo_q    <= '0;
      wr_a_en <= 1'b0;
      wr_b_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_a_en <= 1'b0;
      wr_b_en <= 1'b0;
      if (beat_en) begin
        if (!half) begin
          lo_q <= data;
        end else begin
          wr_a_en <= (opsel == OP_A);
          wr_b_en <= (opsel == OP_B);
          wr_addr <= addr;
          wr_data <= {data, lo_q};
        end
      end
    end
  end

endmodule

// File: rtl/bigmul_operand_loader.sv
// Loads the A and B operand caches from a framed beat stream, then kicks the
// multiplier and reports completion of the whole load+multiply job.
module bigmul_operand_loader #(
  parameter int unsigned NWORDS = 64,
  parameter int unsigned IN_W   = 32
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      go,
  bigmul_operand_loader_if.slave    s,
  output logic                      wr_a_en,
  output logic                      wr_b_en,
  output logic [$clog2(NWORDS)-1:0] wr_addr,
  output logic [63:0]               wr_data,
  output logic                      mul_start,
  input  logic                      mul_busy,
  input  logic                      mul_done,
  output logic                      job_done,
  output logic                      frame_err,
  output logic                      loader_busy
);
  import bigmul_pkg::*;

  localparam int unsigned BPW      = 64 / IN_W;
  localparam int unsigned NBEATS   = 2 * NWORDS * BPW;
  localparam int unsigned AW       = $clog2(NWORDS);
  localparam int unsigned CW       = $clog2(NBEATS);

  loader_state_e   state_q, state_d;
  logic [CW-1:0]   bcnt_q, bcnt_d;
  logic            err_q, err_d;
  logic            start_d, done_d;
  logic            ready, accept, is_last, beat_en;

  assign ready       = (state_q == ST_LOAD);
  assign s.ready     = ready;
  assign accept      = s.valid & ready;
  assign is_last     = (bcnt_q == CW'(NBEATS - 1));
  assign frame_err   = err_q;
  assign loader_busy = (state_q != ST_IDLE);

  // State, beat counter, sticky error and the registered pulse outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      bcnt_q    <= '0;
      err_q     <= 1'b0;
      mul_start <= 1'b0;
      job_done  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      err_q     <= err_d;
      mul_start <= start_d;
      job_done  <= done_d;
    end
  end

  // Next-state, framing checks and pulse requests.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    err_d   = err_q;
    start_d = 1'b0;
    done_d  = 1'b0;
    beat_en = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_LOAD;
          bcnt_d  = '0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          // A framing fault drops the beat, so a half-built word is never written.
          if (s.last != is_last) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            beat_en = 1'b1;
            bcnt_d  = bcnt_q + 1'b1;
            if (is_last) state_d = ST_KICK;
          end
        end
      end
      ST_KICK: begin
        if (!mul_busy) begin
          start_d = 1'b1;
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        // Ignore any mul_done left over from the previous job until busy is seen.
        if (mul_busy) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (mul_done && !mul_busy) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  bigmul_word_packer #(
    .IN_W   (IN_W),
    .ADDR_W (AW)
  ) u_packer (
    .clk     (clk),
    .rstn    (rstn),
    .beat_en (beat_en),
    .half    (bcnt_q[BC_HALF_BIT]),
    .addr    (bcnt_q[BC_ADDR_LSB +: AW]),
    .opsel   (bcnt_q[BC_OPSEL_BIT]),
    .data    (s.data),
    .wr_a_en (wr_a_en),
    .wr_b_en (wr_b_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

endmodule

// File: tb/tb_bigmul_operand_loader.sv
// Scoreboard bench for bigmul_operand_loader with a behavioural multiplier.
module tb_bigmul_operand_loader;
  localparam int NW  = 64;
  localparam int IW  = 32;
  localparam int NB  = 256;
  localparam int LAT = 12;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        go = 1'b0;
  logic        mul_busy = 1'b0;
  logic        mul_done = 1'b0;
  logic        wr_a_en, wr_b_en, mul_start, job_done, frame_err, loader_busy;
  logic [5:0]  wr_addr;
  logic [63:0] wr_data;

  bigmul_operand_loader_if #(.IN_W(IW)) sif ();

  bigmul_operand_loader #(.NWORDS(NW), .IN_W(IW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .go          (go),
    .s           (sif),
    .wr_a_en     (wr_a_en),
    .wr_b_en     (wr_b_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .mul_start   (mul_start),
    .mul_busy    (mul_busy),
    .mul_done    (mul_done),
    .job_done    (job_done),
    .frame_err   (frame_err),
    .loader_busy (loader_busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    bit        sel;
    bit [5:0]  addr;
    bit [63:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] beats[NB];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nwr = 0;
  int exp_start_cyc = 0;
  int done_cyc = 0;
  int mcnt = 0;
  bit start_pending = 0;
  bit job_pending = 0;
  bit hold_busy = 0;
  bit stale_done = 0;
  bit mdone = 0;
  bit prev_acc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bad(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural multiplier: busy for LAT cycles after start, then done level.
  initial begin
    bit st;
    forever begin
      @(negedge clk);
      st = mul_start;
      @(posedge clk);
      #1;
      if (st) begin
        mdone = 0;
        mcnt  = LAT;
      end else if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          mdone    = 1;
          done_cyc = cyc;
        end
      end
      mul_busy = hold_busy || (mcnt > 0);
      mul_done = mdone || stale_done;
    end
  end

  // Monitor: pops expected writes and checks start/job_done timing.
  initial forever begin
    wr_t e;
    @(negedge clk);
    if (wr_a_en || wr_b_en) begin
      nwr++;
      chk("wr_latency", 64'(prev_acc), 64'd1);
      chk("wr_onehot", 64'(wr_a_en & wr_b_en), 64'd0);
      if (exp_q.size() == 0) begin
        bad("wr_unexpected", int'(wr_addr), -1);
      end else begin
        e = exp_q.pop_front();
        chk("wr_sel", 64'(wr_b_en), 64'(e.sel));
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_data", wr_data, e.data);
      end
    end
    prev_acc = sif.valid & sif.ready;
    if (mul_start) begin
      if (!start_pending) bad("start_unexpected", cyc, -1);
      else begin
        chk("start_cycle", 64'(cyc), 64'(exp_start_cyc));
        start_pending = 0;
      end
    end
    if (job_done) begin
      if (!job_pending) bad("job_done_unexpected", cyc, -1);
      else begin
        chk("job_done_cycle", 64'(cyc), 64'(done_cyc + 1));
        job_pending = 0;
      end
    end
  end

  task automatic pulse_go();
    @(posedge clk); #1 go = 1'b1;
    @(posedge clk); #1 go = 1'b0;
  endtask

  // last_at: beat carrying s_last (>= NB means never); abort_at: beat index
  // at which reset is applied instead (-1 none); kick: expect a start/job.
  task automatic send_frame(input int stall_pct, input int last_at, input int abort_at,
                            input bit rnd, input bit kick);
    int  err_beat;
    int  ndrive;
    int  acc_cyc;
    int  waits;
    bit  acc;
    wr_t w;
    err_beat = (last_at < NB - 1) ? last_at : ((last_at > NB - 1) ? NB - 1 : -1);
    ndrive   = (err_beat >= 0) ? err_beat + 1 : ((abort_at >= 0) ? abort_at : NB);
    for (int k = 0; k < NB; k++) beats[k] = rnd ? $urandom : 32'(k);
    for (int g = 0; g < 2*NW; g++) begin
      if ((err_beat >= 0 && 2*g + 1 >= err_beat) || (abort_at >= 0 && 2*g + 1 >= abort_at))
        continue;
      w.sel  = (g >= NW);
      w.addr = 6'(g % NW);
      w.data = {beats[2*g+1], beats[2*g]};
      exp_q.push_back(w);
    end
    pulse_go();
    acc_cyc = 0;
    for (int k = 0; k < ndrive; k++) begin
      waits = 0;
      do begin
        sif.valid = ($urandom_range(99) >= stall_pct);
        sif.data  = beats[k];
        sif.last  = (k == last_at);
        @(negedge clk);
        acc = sif.valid & sif.ready;
        if (acc) acc_cyc = cyc;
        @(posedge clk); #1;
        waits++;
      end while (!acc && waits < 1000);
      if (!acc) begin
        bad("beat_accept_timeout", k, -1);
        break;
      end
    end
    sif.valid = 1'b0;
    sif.last  = 1'b0;
    if (abort_at >= 0) begin
      rstn = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_ctl", {sif.ready, wr_a_en, wr_b_en, wr_addr, mul_start, job_done, frame_err, loader_busy},
          64'd0);
      chk("rst_wr_data", wr_data, 64'd0);
      @(posedge clk); #1 rstn = 1'b1;
      repeat (10) @(posedge clk);
      chk("rst_writes_drained", 64'(exp_q.size()), 64'd0);
    end else if (err_beat < 0 && kick) begin
      exp_start_cyc = acc_cyc + 2;
      start_pending = 1;
      job_pending   = 1;
    end
  endtask

  task automatic wait_job(input string name);
    int n;
    n = 0;
    while ((start_pending || job_pending) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_completed"}, 64'({start_pending, job_pending}), 64'd0);
    @(negedge clk);
    chk({name, "_idle"}, 64'({loader_busy, frame_err, sif.ready}), 64'd0);
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_err(input string name, input int exp_writes, input int nwr0);
    repeat (4) @(negedge clk);
    chk({name, "_frame_err"}, 64'(frame_err), 64'd1);
    chk({name, "_idle"}, 64'({loader_busy, sif.ready}), 64'd0);
    chk({name, "_writes"}, 64'(nwr - nwr0), 64'(exp_writes));
    chk({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int nwr0;
    sif.valid = 1'b0;
    sif.data  = '0;
    sif.last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctl", {sif.ready, wr_a_en, wr_b_en, wr_addr, mul_start, job_done, frame_err, loader_busy},
        64'd0);
    chk("reset_wr_data", wr_data, 64'd0);
    @(posedge clk); #1 rstn = 1'b1;

    // Clean frame, beat k = k, no stalls.
    nwr0 = nwr;
    send_frame(0, NB - 1, -1, 1'b0, 1'b1);
    wait_job("clean");
    chk("clean_writes", 64'(nwr - nwr0), 64'd128);

    // Same frame with ~50% valid stalls.
    nwr0 = nwr;
    send_frame(50, NB - 1, -1, 1'b0, 1'b1);
    wait_job("stall");
    chk("stall_writes", 64'(nwr - nwr0), 64'd128);

    // Early s_last on beat 100: A[0..49] written, no start.
    nwr0 = nwr;
    send_frame(0, 100, -1, 1'b1, 1'b0);
    check_err("early_last", 50, nwr0);
    pulse_go();
    @(negedge clk);
    chk("go_clears_err", 64'({frame_err, loader_busy}), 64'b01);

    // Missing s_last on beat 255 (loader already armed; extra go is ignored).
    nwr0 = nwr;
    send_frame(20, NB + 10, -1, 1'b1, 1'b0);
    check_err("missing_last", 127, nwr0);

    // Multiplier busy at KICK for 10 cycles.
    @(negedge clk) hold_busy = 1;
    send_frame(0, NB - 1, -1, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("kick_hold_busy", 64'({loader_busy, sif.ready}), 64'b10);
    hold_busy     = 0;
    exp_start_cyc = cyc + 2;
    start_pending = 1;
    job_pending   = 1;
    wait_job("busy_hold");

    // Stale mul_done asserted before start.
    @(negedge clk) stale_done = 1;
    send_frame(30, NB - 1, -1, 1'b1, 1'b1);
    wait_job("stale_done");
    @(negedge clk) stale_done = 0;

    // Reset at beat 130, then a fresh frame.
    send_frame(0, NB - 1, 130, 1'b1, 1'b0);
    nwr0 = nwr;
    send_frame(25, NB - 1, -1, 1'b1, 1'b1);
    wait_job("after_reset");
    chk("after_reset_writes", 64'(nwr - nwr0), 64'd128);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
